riscv_instr_encoder: RTL
========================

Name: riscv_instr_encoder

Overview:
Inverse of the main decoder. Accepts decoded instruction fields (class, registers, funct3, immediate) over a valid/ready stream and emits packed 32-bit RV32I instruction words with sequential instruction-memory word addresses. Rejects illegal field combinations. Feeds the instruction-memory loader and the self-check path of the core bench.

Parameters:
ADDR_W, 6, output word-address width; the address counter wraps at 2**ADDR_W
CNT_W, 8, width of the saturating reject counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; clears the address counter and the done flag
in_valid  in  1  input fields valid
in_ready  out  1  encoder can accept fields
in_class  in  3  0=LW 1=SW 2=R 3=BRANCH 4=ITYPE 5=JAL; 6-7 illegal
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  funct3 for R/ITYPE/BRANCH; ignored for LW/SW/JAL
in_funct7b5  in  1  bit 30 for R (sub/sra) and ITYPE shifts
in_imm  in  32  signed immediate (byte offset for BRANCH/JAL)
in_last  in  1  marks the final instruction of a program
out_valid  out  1  encoded word valid
out_ready  in  1  consumer accepts the word
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  word address of out_instr
done  out  1  high from acceptance of the in_last word until start or reset
rej_pulse  out  1  one-cycle pulse when an input is rejected
rej_count  out  CNT_W  saturating count of rejected inputs

Behaviour:
- Reset: out_valid=0, out_instr=0, out_addr=0, done=0, rej_pulse=0, rej_count=0; the address counter is 0.
- Reset mid-transfer discards any held word.
- Single output register stage.
  - in_ready = !out_valid || out_ready (combinational).
  - An input is accepted when in_valid && in_ready.
  - A legal input appears on out_* on the next cycle; latency is 1.
- out_* hold stable while out_valid && !out_ready.
- Output handshake (out_valid && out_ready): the address counter increments and wraps from 2**ADDR_W-1 to 0.
- out_addr is the counter value captured at acceptance.
- Back-to-back legal inputs with out_ready=1 produce one word per cycle.
- Encodings, with op = bits [6:0]:
  - LW: imm[11:0], rs1, 010, rd, 0000011.
  - SW: imm[11:5], rs2, rs1, 010, imm[4:0], 0100011.
  - R: 0, funct7b5, 00000, rs2, rs1, funct3, rd, 0110011.
  - ITYPE: imm[11:0], rs1, funct3, rd, 0010011. For funct3=001 or 101, bits [31:25] = {0, funct7b5, 00000} and bits [24:20] = imm[4:0].
  - BRANCH: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011.
  - JAL: imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111.
- Rejection rules. The input is accepted (in_ready handshake completes) but produces no output word when any of these hold:
  - class 6 or 7;
  - LW, SW or ITYPE with imm outside -2048..2047;
  - ITYPE shift (funct3 001/101) with imm outside 0..31;
  - funct7b5=1 on ITYPE funct3=001;
  - BRANCH with funct3 not in {000, 001, 100, 101} (beq/bne/blt/bge), or imm odd, or imm outside -4096..4094;
  - JAL with imm odd or outside -1048576..1048574;
  - R with funct7b5=1 and funct3 not in {000, 101}.
- On rejection:
  - rej_pulse=1 for one cycle;
  - rej_count increments and saturates at all-ones;
  - the address counter does not advance;
  - out_valid for any previously held word is unaffected.
- in_last on a rejected input still sets done.
- done is set on the cycle after acceptance of an in_last input.
- start clears the counter and done on the next edge.
  - If start coincides with an output handshake, start wins: counter=0.
  - A word already held keeps its captured out_addr.
  - If start coincides with an in_last acceptance, done=1 (the set wins).

Decomposition:
- Package riscv_enc_pkg holds:
  - the instr_class_t enum (LW..JAL);
  - opcode constants OP_LW, OP_SW, OP_R, OP_BR, OP_I, OP_JAL (the same values the main decoder matches);
  - the NOP constant 32'h00000013.
- One combinational sub-module, riscv_imm_pack, takes class, imm and funct fields and returns the packed word and a legal flag.
- The top module holds the handshake register, the address counter, done and rej_count.

Test Plan:
- Reset, then class ITYPE, rd=1, rs1=0, funct3=000, imm=5, out_ready=1 -> next cycle out_instr=0x00500093, out_addr=0.
- LW rd=6, rs1=9, imm=-4, then SW rs2=6, rs1=9, imm=8 -> 0xFFC4A303 at addr 0, then 0x0064A423 at addr 1.
- R add rd=3, rs1=1, rs2=2, followed by the same fields with funct7b5=1 -> 0x002081B3, then 0x402081B3. BRANCH beq rs1=4, rs2=4, imm=8 -> 0x00420463.
- ITYPE imm=2048; BRANCH imm=7; class 7 -> three rej_pulse, rej_count=3, no out_valid, out_addr of the next legal word unchanged.
- out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 after the first accept and out_instr stable; the first word is accepted on release; no loss or duplication.
- Stream 2**ADDR_W+1 legal words with in_last on the final word -> addresses wrap to 0 and done=1. start pulse -> done=0 and the next word lands at addr 0.

Source files
------------

// File: rtl/riscv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Opcode values match the ones the main decoder matches on.
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        CL_LW  = 3'd0,
        CL_SW  = 3'd1,
        CL_R   = 3'd2,
        CL_BR  = 3'd3,
        CL_I   = 3'd4,
        CL_JAL = 3'd5
    } instr_class_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [31:0] NOP = 32'h00000013;

    function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/riscv_imm_pack.sv
// Combinational field packer: builds the RV32I word for one decoded
// instruction and flags field combinations that cannot be encoded.
module riscv_imm_pack
    import riscv_enc_pkg::*;
(
    input  logic [2:0]  class_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        legal_o
);

    logic signed [31:0] imm_s;
    logic               is_shift;
    logic               imm12_ok;

    assign imm_s    = $signed(imm_i);
    assign is_shift = (funct3_i == 3'b001) || (funct3_i == 3'b101);
    assign imm12_ok = in_range(imm_s, -2048, 2047);

    always_comb begin
        instr_o = NOP;
        legal_o = 1'b0;
        case (class_i)
            CL_LW: begin
                legal_o = imm12_ok;
                instr_o = {imm_i[11:0], rs1_i, 3'b010, rd_i, OP_LW};
            end
            CL_SW: begin
                legal_o = imm12_ok;
                instr_o = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], OP_SW};
            end
            CL_R: begin
                // Only add/sub and srl/sra have a bit-30 variant.
                legal_o = !funct7b5_i || (funct3_i == 3'b000) || (funct3_i == 3'b101);
                instr_o = {1'b0, funct7b5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
            end
            CL_BR: begin
                legal_o = (funct3_i inside {3'b000, 3'b001, 3'b100, 3'b101})
                          && !imm_i[0] && in_range(imm_s, -4096, 4094);
                instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], OP_BR};
            end
            CL_I: begin
                if (is_shift) begin
                    // slli has no arithmetic variant; srli/srai share funct3 101.
                    legal_o = in_range(imm_s, 0, 31)
                              && !((funct3_i == 3'b001) && funct7b5_i);
                    instr_o = {1'b0, funct7b5_i, 5'b00000, imm_i[4:0], rs1_i,
                               funct3_i, rd_i, OP_I};
                end else begin
                    legal_o = imm12_ok;
                    instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
                end
            end
            CL_JAL: begin
                legal_o = !imm_i[0] && in_range(imm_s, -1048576, 1048574);
                instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
            end
            default: begin
                legal_o = 1'b0;
                instr_o = NOP;
            end
        endcase
    end

endmodule

// File: rtl/riscv_instr_encoder.sv
// Stream encoder: one output register stage, word-address counter,
// program-done flag and saturating reject counter around riscv_imm_pack.
module riscv_instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        in_class_i,
    input  logic [4:0]        in_rd_i,
    input  logic [4:0]        in_rs1_i,
    input  logic [4:0]        in_rs2_i,
    input  logic [2:0]        in_funct3_i,
    input  logic              in_funct7b5_i,
    input  logic [31:0]       in_imm_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_instr_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              done_o,
    output logic              rej_pulse_o,
    output logic [CNT_W-1:0]  rej_count_o
);

    logic              out_valid_q, out_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              rej_q, rej_d;
    logic [CNT_W-1:0]  rejcnt_q, rejcnt_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        fire;

    riscv_imm_pack u_pack (
        .class_i    (in_class_i),
        .rd_i       (in_rd_i),
        .rs1_i      (in_rs1_i),
        .rs2_i      (in_rs2_i),
        .funct3_i   (in_funct3_i),
        .funct7b5_i (in_funct7b5_i),
        .imm_i      (in_imm_i),
        .instr_o    (enc_word),
        .legal_o    (enc_legal)
    );

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign fire       = out_valid_q && out_ready_i;

    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        rej_d       = 1'b0;
        rejcnt_d    = rejcnt_q;

        if (fire) begin
            out_valid_d = 1'b0;
            cnt_d       = cnt_q + 1'b1;
        end
        if (start_i) begin
            cnt_d = '0;
        end

        // A new word takes the counter value after this cycle's handshake/start,
        // so back-to-back words get consecutive addresses.
        if (accept) begin
            if (enc_legal) begin
                out_valid_d = 1'b1;
                instr_d     = enc_word;
                addr_d      = cnt_d;
            end else begin
                rej_d = 1'b1;
                if (rejcnt_q != '1) begin
                    rejcnt_d = rejcnt_q + 1'b1;
                end
            end
        end

        if (start_i) begin
            done_d = 1'b0;
        end
        if (accept && in_last_i) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            rej_q       <= 1'b0;
            rejcnt_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            rej_q       <= rej_d;
            rejcnt_q    <= rejcnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_instr_o = instr_q;
    assign out_addr_o  = addr_q;
    assign done_o      = done_q;
    assign rej_pulse_o = rej_q;
    assign rej_count_o = rejcnt_q;

endmodule
